apb_master: RTL and testbench

//  APB4 initiator that drives the timer's APB slave port (psel/penable/pwrite/paddr/pwdata/pstrb)

---
 rtl/apb_master_if.sv | 47 ++++
 rtl/apb_master.sv | 107 ++++++++++
 tb/tb_apb_master.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// Command/response channel plus APB4 initiator pins for apb_master.
// The master modport is the initiator's view; slave is the environment side
// (command source, response sink and the APB target).
interface apb_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_strb;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_slverr;
  logic              rsp_timeout;
  logic              busy;

  logic              m_psel;
  logic              m_penable;
  logic              m_pwrite;
  logic [ADDR_W-1:0] m_paddr;
  logic [DATA_W-1:0] m_pwdata;
  logic [STRB_W-1:0] m_pstrb;
  logic [DATA_W-1:0] m_prdata;
  logic              m_pready;
  logic              m_pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  rsp_ready, m_prdata, m_pready, m_pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, busy,
    output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output rsp_ready, m_prdata, m_pready, m_pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, busy,
    input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb
  );
endinterface

// File: rtl/apb_master.sv
// APB4 initiator: one transfer at a time from a valid/ready command channel,
// result returned on a response channel, with a bounded wait on pready.
// All outputs come straight from flops.
module apb_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  apb_master_if.master  bus
);
  // Counter must reach TIMEOUT without wrapping; 1 bit is enough when disabled.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept, done, expire;
  logic             psel_d, penable_d, cmd_ready_d, rsp_valid_d, busy_d;

  assign accept = (state == IDLE) && bus.cmd_valid && bus.cmd_ready;
  assign done   = (state == ACCESS) && bus.m_pready;
  // Abort on the edge that would make this the TIMEOUT-th stalled ACCESS cycle.
  assign expire = (TIMEOUT != 0) && (state == ACCESS) && !bus.m_pready &&
                  (int'(wait_cnt) + 1 >= TIMEOUT);

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done || expire) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs decoded from the next state so they can be registered.
  always_comb begin
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  // Registered control outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bus.m_psel    <= 1'b0;
      bus.m_penable <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.m_psel    <= psel_d;
      bus.m_penable <= penable_d;
      bus.cmd_ready <= cmd_ready_d;
      bus.rsp_valid <= rsp_valid_d;
      bus.busy      <= busy_d;
    end
  end

  // Wait-state counter: cleared in SETUP, counts stalled ACCESS cycles.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                            wait_cnt <= '0;
    else if (state == SETUP)                   wait_cnt <= '0;
    else if (state == ACCESS && !bus.m_pready) wait_cnt <= wait_cnt + CNT_W'(1);
  end

  // Command capture and response capture; addr/data/pwrite hold when idle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bus.m_paddr     <= '0;
      bus.m_pwrite    <= 1'b0;
      bus.m_pwdata    <= '0;
      bus.m_pstrb     <= '0;
      bus.rsp_rdata   <= '0;
      bus.rsp_slverr  <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else if (accept) begin
      bus.m_paddr  <= bus.cmd_addr;
      bus.m_pwrite <= bus.cmd_write;
      bus.m_pwdata <= bus.cmd_wdata;
      bus.m_pstrb  <= bus.cmd_write ? bus.cmd_strb : '0;
    end else if (done) begin
      bus.m_pstrb     <= '0;
      bus.rsp_rdata   <= bus.m_pwrite ? '0 : bus.m_prdata;
      bus.rsp_slverr  <= bus.m_pslverr;
      bus.rsp_timeout <= 1'b0;
    end else if (expire) begin
      bus.m_pstrb     <= '0;
      bus.rsp_rdata   <= '0;
      bus.rsp_slverr  <= 1'b1;
      bus.rsp_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed scenarios plus randomized
// transfers, all judged against a cycle-level timeline computed per transfer.
module tb_apb_master;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = DATA_W / 8;
  localparam int TIMEOUT = 4;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  int   checks    = 0;
  int   failures  = 0;

  always #5 sys_clk = ~sys_clk;

  apb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus.master)
  );

  task automatic drive_idle();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.rsp_ready = 1'b0;
    bus.m_prdata  = '0;
    bus.m_pready  = 1'b0;
    bus.m_pslverr = 1'b0;
  endtask

  // Full transfer: command handshake, APB phases, response with rdly cycles
  // of back-pressure. A pending cmd_valid with junk fields is kept up the whole
  // time to show the master ignores it outside IDLE.
  task automatic run_txn(input bit wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [STRB_W-1:0] strb,
                         input int waits, input bit serr, input logic [DATA_W-1:0] rdata,
                         input int rdly, input string tag);
    bit                to;
    int                ac, last;
    logic [DATA_W-1:0] er;
    logic [STRB_W-1:0] es_strb;
    bit                es;
    bit                ep, en, ev;
    to      = (TIMEOUT != 0) && (waits >= TIMEOUT);
    ac      = to ? TIMEOUT : waits + 1;   // ACCESS cycles
    er      = (to || wr) ? '0 : rdata;
    es      = to ? 1'b1 : serr;
    es_strb = wr ? strb : '0;
    last    = 2 + ac + rdly;              // cycle in which rsp_ready is high

    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s cmd_ready before accept got=%b exp=1", tag, bus.cmd_ready);
    end
    @(negedge sys_clk);

    for (int k = 1; k <= last; k++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'($urandom);
      bus.cmd_addr  = ADDR_W'($urandom);
      bus.cmd_wdata = $urandom;
      bus.cmd_strb  = STRB_W'($urandom);
      ep = (k <= 1 + ac);
      en = (k >= 2) && (k <= 1 + ac);
      ev = (k >= 2 + ac);
      checks++;
      if ({bus.m_psel, bus.m_penable, bus.rsp_valid, bus.cmd_ready, bus.busy} !==
          {ep, en, ev, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL %s ctl k=%0d psel/pen/rv/crdy/busy got=%b exp=%b", tag, k,
                 {bus.m_psel, bus.m_penable, bus.rsp_valid, bus.cmd_ready, bus.busy},
                 {ep, en, ev, 1'b0, 1'b1});
      end
      if (ep) begin
        checks++;
        if ({bus.m_paddr, bus.m_pwrite, bus.m_pwdata, bus.m_pstrb} !== {addr, wr, wdata, es_strb}) begin
          failures++;
          $display("FAIL %s apb_fields k=%0d got=%h/%b/%h/%h exp=%h/%b/%h/%h", tag, k,
                   bus.m_paddr, bus.m_pwrite, bus.m_pwdata, bus.m_pstrb, addr, wr, wdata, es_strb);
        end
      end else begin
        checks++;
        if (bus.m_pstrb !== '0) begin
          failures++;
          $display("FAIL %s pstrb_after k=%0d got=%h exp=0", tag, k, bus.m_pstrb);
        end
      end
      if (ev) begin
        checks++;
        if ({bus.rsp_rdata, bus.rsp_slverr, bus.rsp_timeout} !== {er, es, to}) begin
          failures++;
          $display("FAIL %s rsp k=%0d got=%h/%b/%b exp=%h/%b/%b", tag, k,
                   bus.rsp_rdata, bus.rsp_slverr, bus.rsp_timeout, er, es, to);
        end
      end
      // Slave: complete on ACCESS cycle index 'waits'; noise everywhere else.
      if (en && (k - 2 == waits)) begin
        bus.m_pready  = 1'b1;
        bus.m_prdata  = rdata;
        bus.m_pslverr = serr;
      end else if (en) begin
        bus.m_pready  = 1'b0;
        bus.m_prdata  = $urandom;
        bus.m_pslverr = 1'($urandom);
      end else begin
        bus.m_pready  = 1'($urandom);
        bus.m_prdata  = $urandom;
        bus.m_pslverr = 1'($urandom);
      end
      bus.rsp_ready = (k == last);
      @(negedge sys_clk);
    end

    checks++;
    if ({bus.rsp_valid, bus.cmd_ready, bus.busy, bus.m_psel, bus.m_penable, bus.m_pstrb, bus.m_paddr} !==
        {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {STRB_W{1'b0}}, addr}) begin
      failures++;
      $display("FAIL %s idle_after rv/crdy/busy/psel/pen=%b pstrb=%h paddr=%h exp 01000/0/%h", tag,
               {bus.rsp_valid, bus.cmd_ready, bus.busy, bus.m_psel, bus.m_penable},
               bus.m_pstrb, bus.m_paddr, addr);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.m_pready  = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    drive_idle();
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout, bus.busy,
         bus.m_psel, bus.m_penable, bus.m_pwrite} !== 8'b1000_0000) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=10000000", {bus.cmd_ready, bus.rsp_valid, bus.rsp_slverr,
               bus.rsp_timeout, bus.busy, bus.m_psel, bus.m_penable, bus.m_pwrite});
    end
    checks++;
    if ({bus.m_paddr, bus.m_pwdata, bus.m_pstrb, bus.rsp_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_data paddr=%h pwdata=%h pstrb=%h rdata=%h exp all 0",
               bus.m_paddr, bus.m_pwdata, bus.m_pstrb, bus.rsp_rdata);
    end
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_write();
    run_txn(1'b1, 12'h000, 32'h0000_0003, 4'hF, 0, 1'b0, 32'h1234_5678, 0, "write");
  endtask

  task automatic test_read_wait();
    run_txn(1'b0, 12'h004, 32'h5555_AAAA, 4'hF, 3, 1'b0, 32'hDEAD_BEEF, 0, "read_wait");
  endtask

  task automatic test_slverr();
    run_txn(1'b1, 12'h008, 32'hCAFE_0001, 4'h3, 0, 1'b1, 32'h0, 1, "slverr");
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 12'h00C, 32'h0, 4'h0, 50, 1'b0, 32'hFFFF_FFFF, 0, "timeout");
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 12'h010, 32'h0, 4'h0, 0, 1'b0, 32'h0BAD_F00D, 5, "backpressure");
    run_txn(1'b1, 12'h014, 32'h0101_0101, 4'h5, 1, 1'b0, 32'h0, 0, "b2b");
  endtask

  task automatic test_reset_mid();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 12'h020;
    bus.m_pready  = 1'b0;
    @(negedge sys_clk);
    bus.cmd_valid = 1'b0;
    @(negedge sys_clk);
    checks++;
    if ({bus.m_psel, bus.m_penable} !== 2'b11) begin
      failures++;
      $display("FAIL rst_mid in_access got=%b exp=11", {bus.m_psel, bus.m_penable});
    end
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.m_psel, bus.m_penable, bus.rsp_valid, bus.cmd_ready, bus.busy} !== 5'b00010) begin
      failures++;
      $display("FAIL rst_mid async got=%b exp=00010",
               {bus.m_psel, bus.m_penable, bus.rsp_valid, bus.cmd_ready, bus.busy});
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    run_txn(1'b0, 12'h024, 32'h0, 4'h0, 2, 1'b0, 32'h600D_CAFE, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_txn(1'($urandom), ADDR_W'($urandom), $urandom, STRB_W'($urandom),
              int'($urandom_range(0, 6)), 1'($urandom), $urandom,
              int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
